scmp_bus_responder: RTL and testbench

Memory-side responder for the SC/MP external bus. Latches the 16-bit address and cycle flags at the address strobe, then services the following read or write strobe from an internal byte RAM, inserting parameterised wait states via `hold_n`. Sits between the CPU core's bus pins and on-chip memory, and is the target end of the core's ADS_n/RD_n/WR_n protocol.

---
 rtl/scmp_bus_responder_pkg.sv | 21 ++
 rtl/scmp_bus_responder_if.sv | 31 +++
 rtl/scmp_bus_responder_ram.sv | 21 ++
 rtl/scmp_bus_responder.sv | 167 ++++++++++++++++
 tb/tb_scmp_bus_responder.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/scmp_bus_responder_pkg.sv
// Shared types and constants for the SC/MP bus responder: FSM state encoding,
// cycle-flag bit positions and the CPU address width.
package scmp_bus_pkg;

  localparam int ADDR_W = 16;

  localparam int FLAG_H = 3;
  localparam int FLAG_D = 2;
  localparam int FLAG_I = 1;
  localparam int FLAG_R = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDRESSED = 3'd1,
    ST_RD_WAIT   = 3'd2,
    ST_RD_DATA   = 3'd3,
    ST_WR_WAIT   = 3'd4,
    ST_WR_DONE   = 3'd5
  } resp_state_t;

endpackage

// File: rtl/scmp_bus_responder_if.sv
// SC/MP external bus as seen between the CPU core (master) and a memory
// responder (slave). Clock and reset are carried separately.
interface scmp_bus_responder_if;

  // Strobes are active-low levels sampled on the rising clock edge. A master
  // keeps RD_n/WR_n low until the data phase is reached (D_oe high for reads,
  // write committed for writes); releasing a strobe earlier aborts the cycle.
  // hold_n low means the responder has not yet entered the data phase.
  logic [11:0] addr_i;
  logic [7:0]  D_i;
  logic        ADS_n;
  logic        RD_n;
  logic        WR_n;
  logic [7:0]  D_o;
  logic        D_oe;
  logic        hold_n;
  logic [3:0]  flags_o;
  logic        sel_o;
  logic        err_o;

  modport master (
    output addr_i, D_i, ADS_n, RD_n, WR_n,
    input  D_o, D_oe, hold_n, flags_o, sel_o, err_o
  );

  modport slave (
    input  addr_i, D_i, ADS_n, RD_n, WR_n,
    output D_o, D_oe, hold_n, flags_o, sel_o, err_o
  );

endinterface

// File: rtl/scmp_bus_responder_ram.sv
// Byte RAM behind the responder: synchronous write, combinational read,
// contents are never reset.
module scmp_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/scmp_bus_responder.sv
// Memory-side responder for the SC/MP bus: latches address and cycle flags on
// ADS_n, then services one read or write strobe with optional hold_n waits.
module scmp_bus_responder
  import scmp_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE        = 16'h0000,
  parameter int                AW          = 10,
  parameter int                WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  scmp_bus_responder_if.slave  bus,
  output resp_state_t          state_o
);

  localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  localparam logic        NO_WAIT = (WAIT_STATES == 0);
  localparam logic [16:0] SPAN    = 17'(1) << AW;

  // Offset is 16-bit unsigned; the range check rejects addresses below BASE
  // so a wrapped offset can never alias into the RAM.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE;
    return (a >= BASE) && ({1'b0, off} < SPAN);
  endfunction

  resp_state_t       state;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        wcnt;
  logic [3:0]        flags_q;
  logic              sel_q;
  logic              err_q;
  logic [7:0]        d_o_q;
  logic              d_oe_q;
  logic              hold_q;

  logic [ADDR_W-1:0] next_addr;
  logic [AW-1:0]     ram_addr;
  logic [7:0]        ram_rdata;
  logic              wr_commit;
  logic              ram_we;

  assign next_addr = {bus.D_i[3:0], bus.addr_i};
  assign ram_addr  = AW'(addr_q - BASE);

  // The write lands on the same edge the FSM enters WR_DONE.
  assign wr_commit = (state == ST_ADDRESSED && bus.ADS_n && bus.RD_n && !bus.WR_n && NO_WAIT)
                   || (state == ST_WR_WAIT && !bus.WR_n && wcnt == 4'd0);
  assign ram_we    = wr_commit && sel_q;

  scmp_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (bus.D_i),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wcnt    <= 4'd0;
      flags_q <= 4'd0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
      d_o_q   <= 8'h00;
      d_oe_q  <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          d_oe_q <= 1'b0;
          hold_q <= 1'b1;
          if (!bus.ADS_n) begin
            addr_q  <= next_addr;
            flags_q <= bus.D_i[7:4];
            sel_q   <= in_range(next_addr);
            state   <= ST_ADDRESSED;
          end
        end
        ST_ADDRESSED: begin
          if (!bus.ADS_n) begin
            addr_q  <= next_addr;
            flags_q <= bus.D_i[7:4];
            sel_q   <= in_range(next_addr);
          end else if (!bus.RD_n) begin
            // A simultaneous write strobe is flagged but serviced as a read.
            if (!bus.WR_n) err_q <= 1'b1;
            if (NO_WAIT) begin
              state  <= ST_RD_DATA;
              d_o_q  <= sel_q ? ram_rdata : 8'hFF;
              d_oe_q <= 1'b1;
              if (!sel_q) err_q <= 1'b1;
            end else begin
              state  <= ST_RD_WAIT;
              wcnt   <= WS_LOAD;
              hold_q <= 1'b0;
            end
          end else if (!bus.WR_n) begin
            if (NO_WAIT) begin
              state <= ST_WR_DONE;
              if (!sel_q) err_q <= 1'b1;
            end else begin
              state  <= ST_WR_WAIT;
              wcnt   <= WS_LOAD;
              hold_q <= 1'b0;
            end
          end
        end
        ST_RD_WAIT: begin
          if (bus.RD_n) begin
            state  <= ST_IDLE;
            hold_q <= 1'b1;
            wcnt   <= 4'd0;
          end else if (wcnt == 4'd0) begin
            state  <= ST_RD_DATA;
            hold_q <= 1'b1;
            d_o_q  <= sel_q ? ram_rdata : 8'hFF;
            d_oe_q <= 1'b1;
            if (!sel_q) err_q <= 1'b1;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        ST_RD_DATA: begin
          if (bus.RD_n) begin
            state  <= ST_IDLE;
            d_oe_q <= 1'b0;
          end
        end
        ST_WR_WAIT: begin
          if (bus.WR_n) begin
            state  <= ST_IDLE;
            hold_q <= 1'b1;
            wcnt   <= 4'd0;
          end else if (wcnt == 4'd0) begin
            state  <= ST_WR_DONE;
            hold_q <= 1'b1;
            if (!sel_q) err_q <= 1'b1;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        ST_WR_DONE: begin
          if (bus.WR_n) state <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          d_oe_q <= 1'b0;
          hold_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.D_o     = d_o_q;
  assign bus.D_oe    = d_oe_q;
  assign bus.hold_n  = hold_q;
  assign bus.flags_o = flags_q;
  assign bus.sel_o   = sel_q;
  assign bus.err_o   = err_q;
  assign state_o     = state;

endmodule

// File: tb/tb_scmp_bus_responder.sv
// Bench for scmp_bus_responder: three instances (0, 2 and 3 wait states)
// share one driver; only the selected instance sees active strobes.
module tb_scmp_bus_responder;
  import scmp_bus_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  // ---------------- shared driver signals ----------------
  logic [11:0] t_addr = 12'h000;
  logic [7:0]  t_d = 8'h00;
  logic        t_ads_n = 1'b1;
  logic        t_rd_n = 1'b1;
  logic        t_wr_n = 1'b1;
  int          act = 0;

  logic [7:0]  m_d_o   [3];
  logic        m_oe    [3];
  logic        m_hold  [3];
  logic        m_err   [3];
  logic [3:0]  m_flags [3];
  logic        m_sel   [3];
  logic        m_rd_n  [3];
  resp_state_t m_state [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    scmp_bus_responder_if bus ();
    assign bus.addr_i = t_addr;
    assign bus.D_i    = t_d;
    assign bus.ADS_n  = (act == g) ? t_ads_n : 1'b1;
    assign bus.RD_n   = (act == g) ? t_rd_n  : 1'b1;
    assign bus.WR_n   = (act == g) ? t_wr_n  : 1'b1;
    assign m_d_o[g]   = bus.D_o;
    assign m_oe[g]    = bus.D_oe;
    assign m_hold[g]  = bus.hold_n;
    assign m_err[g]   = bus.err_o;
    assign m_flags[g] = bus.flags_o;
    assign m_sel[g]   = bus.sel_o;
    assign m_rd_n[g]  = bus.RD_n;

    scmp_bus_responder #(
      .BASE        (16'h0000),
      .AW          (10),
      .WAIT_STATES (ws_of(g))
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .state_o (m_state[g])
    );
  end

  // ---------------- scoreboard ----------------
  // entry = {dut[1:0], strobe-to-data latency[4:0], hold cycles[3:0], data[7:0]}
  logic [18:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int err_c  [3] = '{0, 0, 0};
  int hold_c [3] = '{0, 0, 0};
  int lat_c  [3] = '{0, 0, 0};
  logic oe_prev [3] = '{1'b0, 1'b0, 1'b0};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: counts err pulses and hold/latency cycles, pops on each D_oe rise.
  initial begin
    logic [18:0] e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (m_err[k]) err_c[k]++;
        if (m_oe[k] && !oe_prev[k]) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rd_unexpected dut=%0d got data=%h", k, m_d_o[k]);
          end else begin
            e = exp_q.pop_front();
            if (e !== {2'(k), 5'(lat_c[k]), 4'(hold_c[k]), m_d_o[k]}) begin
              bad++;
              $display("FAIL rd_data dut=%0d got lat=%0d hold=%0d data=%h want dut=%0d lat=%0d hold=%0d data=%h",
                       k, lat_c[k], hold_c[k], m_d_o[k], e[18:17], e[16:12], e[11:8], e[7:0]);
            end
          end
          hold_c[k] = 0;
          lat_c[k]  = 0;
        end else begin
          if (!m_hold[k]) hold_c[k]++;
          if (!m_rd_n[k]) lat_c[k]++;
        end
        if (m_state[k] == ST_IDLE && m_rd_n[k]) begin
          hold_c[k] = 0;
          lat_c[k]  = 0;
        end
        oe_prev[k] = m_oe[k];
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic do_addr(input logic [15:0] a, input logic [3:0] flags);
    t_addr  = a[11:0];
    t_d     = {flags, a[15:12]};
    t_ads_n = 1'b0;
    @(posedge clk); #1;
    t_ads_n = 1'b1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] data);
    logic reached;
    reached = 1'b0;
    do_addr(a, 4'b0000);
    t_d    = data;
    t_wr_n = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (m_state[act] == ST_WR_DONE) begin
        reached = 1'b1;
        break;
      end
    end
    check("wr_reach_done", 32'(reached), 32'd1);
    t_wr_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [7:0] data, input logic with_wr);
    logic seen;
    int ws;
    seen = 1'b0;
    ws = ws_of(act);
    exp_q.push_back({2'(act), 5'(ws + 1), 4'(ws), data});
    t_rd_n = 1'b0;
    t_wr_n = with_wr ? 1'b0 : 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (m_oe[act]) begin
        seen = 1'b1;
        break;
      end
    end
    check("rd_reach_data", 32'(seen), 32'd1);
    t_rd_n = 1'b1;
    t_wr_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_d_o",    32'(m_d_o[0]),   32'h00);
    check("rst_d_oe",   32'(m_oe[0]),    32'd0);
    check("rst_hold_n", 32'(m_hold[0]),  32'd1);
    check("rst_flags",  32'(m_flags[0]), 32'd0);
    check("rst_sel",    32'(m_sel[0]),   32'd0);
    check("rst_err",    32'(m_err[1]),   32'd0);
    check("rst_state",  32'(m_state[2]), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // No wait states: read of a preloaded byte with R flag.
    act = 0;
    e0 = err_c[0];
    do_write(16'h0005, 8'hA5);
    do_addr(16'h0005, 4'b0001);
    check("ws0_flags", 32'(m_flags[0]), 32'h1);
    check("ws0_sel",   32'(m_sel[0]),   32'd1);
    do_read(8'hA5, 1'b0);
    do_write(16'h0123, 8'h3C);
    do_addr(16'h0123, 4'b1010);
    check("flags_hi", 32'(m_flags[0]), 32'hA);
    do_read(8'h3C, 1'b0);
    check("ws0_no_err", 32'(err_c[0] - e0), 32'd0);

    // Last mapped byte and first unmapped one.
    do_write(16'h03FF, 8'hC3);
    do_addr(16'h03FF, 4'b0000);
    check("sel_top", 32'(m_sel[0]), 32'd1);
    do_read(8'hC3, 1'b0);
    do_addr(16'h0400, 4'b0000);
    check("sel_above", 32'(m_sel[0]), 32'd0);

    // Out of range read and write; 0x0800 aliases offset 0 in the low bits.
    do_write(16'h0000, 8'h77);
    e0 = err_c[0];
    do_addr(16'h0800, 4'b0000);
    do_read(8'hFF, 1'b0);
    check("oor_rd_err", 32'(err_c[0] - e0), 32'd1);
    e0 = err_c[0];
    do_write(16'h0800, 8'h11);
    check("oor_wr_err", 32'(err_c[0] - e0), 32'd1);
    do_addr(16'h0000, 4'b0000);
    do_read(8'h77, 1'b0);

    // Two wait states.
    act = 1;
    do_write(16'h0200, 8'h5A);
    do_addr(16'h0200, 4'b0000);
    do_read(8'h5A, 1'b0);

    // Three wait states: write aborted after one wait cycle.
    act = 2;
    do_write(16'h0010, 8'h99);
    do_addr(16'h0010, 4'b0000);
    t_d    = 8'h44;
    t_wr_n = 1'b0;
    @(posedge clk); #1;
    check("abort_in_wait", 32'(m_state[2]), 32'(ST_WR_WAIT));
    check("abort_hold_lo", 32'(m_hold[2]),  32'd0);
    @(posedge clk); #1;
    t_wr_n = 1'b1;
    @(posedge clk); #1;
    check("abort_idle",    32'(m_state[2]), 32'(ST_IDLE));
    check("abort_hold_hi", 32'(m_hold[2]),  32'd1);
    do_addr(16'h0010, 4'b0000);
    do_read(8'h99, 1'b0);

    // Asynchronous reset during a read wait.
    do_addr(16'h0020, 4'b0000);
    t_rd_n = 1'b0;
    @(posedge clk); #1;
    check("rw_in_wait", 32'(m_state[2]), 32'(ST_RD_WAIT));
    rst_n = 1'b0;
    #1;
    check("rst_mid_state", 32'(m_state[2]), 32'(ST_IDLE));
    check("rst_mid_oe",    32'(m_oe[2]),    32'd0);
    check("rst_mid_hold",  32'(m_hold[2]),  32'd1);
    t_rd_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Read and write strobes together: read wins, error pulses, no write.
    act = 0;
    do_write(16'h0030, 8'h55);
    e0 = err_c[0];
    do_addr(16'h0030, 4'b0000);
    t_d = 8'hEE;
    do_read(8'h55, 1'b1);
    check("rdwr_err", 32'(err_c[0] - e0), 32'd1);
    do_addr(16'h0030, 4'b0000);
    do_read(8'h55, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
